// File: rtl/conv_array_sequencer_pkg.sv
// Shared encodings for the conv array sequencer: FSM states, input-buffer load modes, op types.
package conv_array_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_CLEAR = 3'd4
  } seq_state_t;

  localparam logic [1:0] LM_FULL = 2'd0;
  localparam logic [1:0] LM_ROW  = 2'd1;
  localparam logic [1:0] LM_COL  = 2'd2;
  localparam logic [1:0] LM_ELEM = 2'd3;

  localparam logic OP_CONV = 1'b0;
  localparam logic OP_FC   = 1'b1;

  // Conv reuses the previous window: a new row strip at ky==0, a new column strip at kx==0.
  function automatic logic [1:0] lm_decode(input logic op, input logic kx_zero, input logic ky_zero);
    if (op == OP_FC || (kx_zero && ky_zero)) return LM_FULL;
    else if (ky_zero)                        return LM_ROW;
    else if (kx_zero)                        return LM_COL;
    else                                     return LM_ELEM;
  endfunction

endpackage

// File: rtl/conv_array_sequencer_kernel_coord_counter.sv
// Nested kx/ky kernel walker (row-major for conv, linear kx for fc) with first/last flags and load_mode.
module conv_array_sequencer_kernel_coord_counter
  import conv_array_sequencer_pkg::*;
#(
  parameter int KSW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic           advance,
  input  logic           op_type,
  input  logic [KSW-1:0] kernel_size,
  output logic [KSW-1:0] kx,
  output logic [KSW-1:0] ky,
  output logic           first,
  output logic           last,
  output logic [1:0]     load_mode
);

  logic [KSW-1:0] k_max;
  logic           kx_end;
  logic           ky_end;

  assign k_max     = kernel_size - 1'b1;
  assign kx_end    = (kx == k_max);
  assign ky_end    = (ky == k_max);
  assign first     = (kx == '0) && (ky == '0);
  assign last      = (op_type == OP_FC) ? kx_end : (kx_end && ky_end);
  assign load_mode = lm_decode(op_type, kx == '0, ky == '0);

  // Wraps to (0,0) on the final issue so the next job starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx <= '0;
      ky <= '0;
    end else if (init) begin
      kx <= '0;
      ky <= '0;
    end else if (advance) begin
      if (last) begin
        kx <= '0;
        ky <= '0;
      end else if (kx_end) begin
        kx <= '0;
        ky <= ky + 1'b1;
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_array_sequencer.sv
// Sequencer for one float16 MAC array output tile: issue, drain, writeback handshake, clear.
// Optional drain watchdog enabled by defining SEQ_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; array held in reset
// ST_ISSUE | one buffer/weight read per cycle, N = K*K (conv) or K (fc)
// ST_DRAIN | reads done, waiting for arr_result_ready
// ST_OUT   | res_valid high until writeback takes the tile
// ST_CLEAR | one cycle with the array back in reset
module conv_array_sequencer
  import conv_array_sequencer_pkg::*;
#(
  parameter int KSW            = 5,
  parameter int WADDR_W        = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_type,
  input  logic [KSW-1:0]     kernel_size,
  input  logic [WADDR_W-1:0] w_base,
  output logic               busy,
  output logic               cfg_err,
  output logic               load_valid,
  output logic [1:0]         load_mode,
  output logic [KSW-1:0]     kx,
  output logic [KSW-1:0]     ky,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_addr,
  output logic               arr_run,
  output logic               arr_op_type,
  output logic [KSW-1:0]     arr_kernel_size,
  input  logic               arr_result_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               timeout_err
);

  seq_state_t state, state_nx;
  logic       accept;
  logic       coord_first;
  logic       coord_last;
  logic       timeout_hit;

  assign accept = (state == ST_IDLE) && start && (kernel_size != '0);

  conv_array_sequencer_kernel_coord_counter #(.KSW(KSW)) u_coord (
    .clk         (clk),
    .rst         (rst),
    .init        (accept),
    .advance     (state == ST_ISSUE),
    .op_type     (arr_op_type),
    .kernel_size (arr_kernel_size),
    .kx          (kx),
    .ky          (ky),
    .first       (coord_first),
    .last        (coord_last),
    .load_mode   (load_mode)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = (state != ST_IDLE);
    load_valid = 1'b0;
    w_rd_en    = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        load_valid = 1'b1;
        w_rd_en    = 1'b1;
        if (coord_last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (arr_result_ready) state_nx = ST_OUT;
        else if (timeout_hit) state_nx = ST_CLEAR;
      end
      ST_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = ST_CLEAR;
      end
      ST_CLEAR: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_op_type     <= 1'b0;
      arr_kernel_size <= '0;
      w_addr          <= '0;
    end else if (accept) begin
      arr_op_type     <= op_type;
      arr_kernel_size <= kernel_size;
      w_addr          <= w_base;
    end else if (state == ST_ISSUE && !coord_last) begin
      w_addr <= w_addr + 1'b1;
    end
  end

  // Array comes out of reset one cycle after the first read, matching the buffers' read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_run <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= (state == ST_IDLE) && start && (kernel_size == '0);
      if (state_nx == ST_CLEAR || state_nx == ST_IDLE) arr_run <= 1'b0;
      else if (state == ST_ISSUE && coord_first)       arr_run <= 1'b1;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;

  assign timeout_hit = (state == ST_DRAIN) && !arr_result_ready && (to_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state != ST_DRAIN)  to_cnt <= TO_LOAD;
      else if (to_cnt != '0)  to_cnt <= to_cnt - 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_conv_array_sequencer.sv
// Directed bench for conv_array_sequencer: conv/fc issue order, handshake, cfg error, abort, watchdog.
module tb_conv_array_sequencer;

  localparam int KSW     = 5;
  localparam int WADDR_W = 10;
  localparam int TO      = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               op_type;
  logic [KSW-1:0]     kernel_size;
  logic [WADDR_W-1:0] w_base;
  logic               busy;
  logic               cfg_err;
  logic               load_valid;
  logic [1:0]         load_mode;
  logic [KSW-1:0]     kx;
  logic [KSW-1:0]     ky;
  logic               w_rd_en;
  logic [WADDR_W-1:0] w_addr;
  logic               arr_run;
  logic               arr_op_type;
  logic [KSW-1:0]     arr_kernel_size;
  logic               arr_result_ready;
  logic               res_valid;
  logic               res_ready;
  logic               timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  conv_array_sequencer #(.KSW(KSW), .WADDR_W(WADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .op_type          (op_type),
    .kernel_size      (kernel_size),
    .w_base           (w_base),
    .busy             (busy),
    .cfg_err          (cfg_err),
    .load_valid       (load_valid),
    .load_mode        (load_mode),
    .kx               (kx),
    .ky               (ky),
    .w_rd_en          (w_rd_en),
    .w_addr           (w_addr),
    .arr_run          (arr_run),
    .arr_op_type      (arr_op_type),
    .arr_kernel_size  (arr_kernel_size),
    .arr_result_ready (arr_result_ready),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic op, input logic [KSW-1:0] k, input logic [WADDR_W-1:0] base);
    op_type     = op;
    kernel_size = k;
    w_base      = base;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  logic [1:0]         conv3_modes [9];
  int                 issues;
  logic [WADDR_W-1:0] last_addr;

  initial begin
    conv3_modes = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3};
    rst = 1'b1; start = 1'b0; op_type = 1'b0; kernel_size = '0; w_base = '0;
    arr_result_ready = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_load_valid", load_valid, 0);
    check("rst_w_rd_en", w_rd_en, 0);
    check("rst_arr_run", arr_run, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_arr_ks", arr_kernel_size, 0);
    rst = 1'b0;
    tick();

    // Conv K=3 from 0x010
    launch(1'b0, 5'd3, 10'h010);
    for (int i = 0; i < 9; i++) begin
      check("c3_load_valid", load_valid, 1);
      check("c3_w_rd_en", w_rd_en, 1);
      check("c3_load_mode", load_mode, conv3_modes[i]);
      check("c3_w_addr", w_addr, 32'h010 + i);
      check("c3_kx", kx, i % 3);
      check("c3_ky", ky, i / 3);
      check("c3_arr_run", arr_run, (i > 0) ? 1 : 0);
      check("c3_busy", busy, 1);
      tick();
    end
    check("c3_drain_load_valid", load_valid, 0);
    check("c3_drain_arr_run", arr_run, 1);
    check("c3_drain_res_valid", res_valid, 0);
    arr_result_ready = 1'b1;
    tick();
    arr_result_ready = 1'b0;
    check("c3_out_res_valid", res_valid, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("c3_clear_arr_run", arr_run, 0);
    check("c3_clear_res_valid", res_valid, 0);
    check("c3_clear_busy", busy, 1);
    tick();
    check("c3_idle_busy", busy, 0);

    // FC K=4 from 0x100, result_ready 3 cycles after last issue, writeback stalls 5 cycles
    launch(1'b1, 5'd4, 10'h100);
    for (int i = 0; i < 4; i++) begin
      check("fc_load_valid", load_valid, 1);
      check("fc_load_mode", load_mode, 0);
      check("fc_w_addr", w_addr, 32'h100 + i);
      check("fc_kx", kx, i);
      check("fc_ky", ky, 0);
      tick();
    end
    check("fc_drain1_res_valid", res_valid, 0);
    tick();
    check("fc_drain2_res_valid", res_valid, 0);
    tick();
    check("fc_drain3_load_valid", load_valid, 0);
    arr_result_ready = 1'b1;
    tick();
    arr_result_ready = 1'b0;
    check("fc_out_res_valid", res_valid, 1);
    check("fc_arr_op_type", arr_op_type, 1);
    check("fc_arr_ks", arr_kernel_size, 4);
    for (int j = 0; j < 5; j++) begin
      tick();
      check("fc_hold_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("fc_clear_arr_run", arr_run, 0);
    check("fc_clear_res_valid", res_valid, 0);
    tick();
    check("fc_idle_busy", busy, 0);
    check("fc_idle_arr_run", arr_run, 0);

    // kernel_size==0 rejected
    launch(1'b0, 5'd0, 10'h000);
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_busy", busy, 0);
    tick();
    check("cfg_err_drop", cfg_err, 0);
    check("cfg_err_busy2", busy, 0);

    // Conv K=5 with a stray start mid-issue
    launch(1'b0, 5'd5, 10'h040);
    issues = 0;
    last_addr = '0;
    for (int c = 0; c < 30; c++) begin
      if (load_valid) begin
        issues++;
        last_addr = w_addr;
      end
      if (c == 10) begin
        start = 1'b1;
        kernel_size = 5'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("k5_issue_count", issues, 25);
    check("k5_last_addr", last_addr, 32'h058);
    check("k5_arr_ks", arr_kernel_size, 5);
    check("k5_busy", busy, 1);
    check("k5_cfg_err", cfg_err, 0);
    arr_result_ready = 1'b1;
    tick();
    arr_result_ready = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    check("k5_idle_busy", busy, 0);

    // Async reset at the 7th issue of a K=3 conv
    launch(1'b0, 5'd3, 10'h010);
    for (int i = 0; i < 6; i++) tick();
    check("abort_pre_mode", load_mode, 2);
    check("abort_pre_w_addr", w_addr, 32'h016);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_load_valid", load_valid, 0);
    check("abort_w_rd_en", w_rd_en, 0);
    check("abort_arr_run", arr_run, 0);
    check("abort_w_addr", w_addr, 0);
    check("abort_kx", kx, 0);
    check("abort_ky", ky, 0);
    check("abort_arr_ks", arr_kernel_size, 0);
    check("abort_res_valid", res_valid, 0);
    #2;
    rst = 1'b0;
    tick();
    launch(1'b0, 5'd3, 10'h020);
    check("restart_mode", load_mode, 0);
    check("restart_w_addr", w_addr, 32'h020);
    check("restart_kx", kx, 0);
    check("restart_ky", ky, 0);
    for (int i = 0; i < 9; i++) tick();
    check("restart_drain_load_valid", load_valid, 0);

    // Drain with no arr_result_ready
`ifdef SEQ_TIMEOUT_EN
    for (int j = 0; j < TO; j++) begin
      check("to_wait_err", timeout_err, 0);
      check("to_wait_busy", busy, 1);
      check("to_wait_res_valid", res_valid, 0);
      tick();
    end
    check("to_pulse", timeout_err, 1);
    check("to_res_valid", res_valid, 0);
    check("to_arr_run", arr_run, 0);
    tick();
    check("to_idle_busy", busy, 0);
    check("to_pulse_drop", timeout_err, 0);
`else
    for (int j = 0; j < 20; j++) begin
      check("nto_busy", busy, 1);
      check("nto_res_valid", res_valid, 0);
      check("nto_timeout_err", timeout_err, 0);
      tick();
    end
    arr_result_ready = 1'b1;
    tick();
    arr_result_ready = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    check("nto_idle_busy", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
